comma_n: RTL



---
 rtl/comma_n_pkg.sv | 17 +
 rtl/comma_n.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/comma_n_pkg.sv
// Shared dictionary-engine types: comma append modes and comma_n FSM states.
package comma_n_pkg;

    typedef enum logic [1:0] {
        CM_B  = 2'd0,
        CM_H  = 2'd1,
        CM_C  = 2'd2,
        CM_AL = 2'd3
    } comma_md;

    typedef enum logic [1:0] {
        CN_IDLE = 2'd0,
        CN_WR   = 2'd1,
        CN_DONE = 2'd2
    } comma_n_sts;

endpackage

// File: rtl/comma_n.sv
// Appends a byte, half-cell or cell to dictionary memory one byte per clock,
// or zero-pads to the next cell boundary; owns the dictionary pointer here.
module comma_n
    import comma_n_pkg::*;
#(
    parameter int DSZ = 8,
    parameter int CSZ = 32,
    parameter int ASZ = 17,
    parameter int BIG = 1
) (
    input  logic           clk,
    input  logic           en,
    input  logic           ld,
    input  logic [ASZ-1:0] hi,
    input  logic           go,
    input  logic [1:0]     md,
    input  logic [CSZ-1:0] vi,
    output logic           bsy,
    output logic           dn,
    output logic [ASZ-1:0] here,
    output logic           mem_we,
    output logic [ASZ-1:0] mem_a,
    output logic [DSZ-1:0] mem_d
);

    localparam int CB = CSZ / 8;
    localparam int CW = $clog2(CB) + 1;
    localparam int NH = (CB > 1) ? CB / 2 : 1;
    localparam logic [ASZ-1:0] A_MSK = ASZ'(CB - 1);

    comma_n_sts st_q, st_d;
    logic [ASZ-1:0] here_q, here_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  n_q, n_d;
    logic [CSZ-1:0] val_q, val_d;
    logic           bsy_q, bsy_d;
    logic           dn_q, dn_d;
    logic           we_q, we_d;
    logic [ASZ-1:0] a_q, a_d;
    logic [DSZ-1:0] d_q, d_d;

    comma_md        md_e;
    logic [CW-1:0]  n_go;
    logic [CSZ-1:0] val_go;
    logic           go_ok;

    // Byte k of an N-byte field; big-endian walks from the top byte down.
    function automatic logic [DSZ-1:0] byte_sel(input logic [CSZ-1:0] v,
                                                input logic [CW-1:0]  k,
                                                input logic [CW-1:0]  n);
        logic [CW-1:0]  idx;
        logic [CSZ-1:0] sh;
        idx = (BIG != 0) ? (n - k - CW'(1)) : k;
        sh  = v >> (DSZ * int'(idx));
        return sh[DSZ-1:0];
    endfunction

    assign md_e   = comma_md'(md);
    assign go_ok  = (st_q == CN_IDLE) && go && !ld;
    // Bytes above the selected field are never indexed, so vi needs no masking.
    assign val_go = (md_e == CM_AL) ? '0 : vi;

    always_comb begin
        n_go = CW'(1);
        case (md_e)
            CM_B:    n_go = CW'(1);
            CM_H:    n_go = CW'(NH);
            CM_C:    n_go = CW'(CB);
            CM_AL:   n_go = (CW'(CB) - CW'(here_q & A_MSK)) & CW'(CB - 1);
            default: n_go = CW'(1);
        endcase
    end

    // Next-state logic
    always_comb begin
        st_d = st_q;
        case (st_q)
            CN_IDLE: if (go_ok) st_d = (n_go == '0) ? CN_DONE : CN_WR;
            CN_WR:   if (cnt_q == n_q) st_d = CN_DONE;
            CN_DONE: st_d = CN_IDLE;
            default: st_d = CN_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        here_d = here_q;
        cnt_d  = cnt_q;
        n_d    = n_q;
        val_d  = val_q;
        bsy_d  = 1'b0;
        dn_d   = 1'b0;
        we_d   = 1'b0;
        a_d    = a_q;
        d_d    = d_q;
        case (st_q)
            CN_IDLE: begin
                if (ld) begin
                    here_d = hi;
                end else if (go) begin
                    val_d = val_go;
                    n_d   = n_go;
                    cnt_d = '0;
                    if (n_go == '0) begin
                        dn_d = 1'b1;
                    end else begin
                        bsy_d = 1'b1;
                        we_d  = 1'b1;
                        a_d   = here_q;
                        d_d   = byte_sel(val_go, '0, n_go);
                        cnt_d = CW'(1);
                    end
                end
            end
            CN_WR: begin
                here_d = here_q + ASZ'(1);
                if (cnt_q == n_q) begin
                    dn_d = 1'b1;
                end else begin
                    bsy_d = 1'b1;
                    we_d  = 1'b1;
                    a_d   = a_q + ASZ'(1);
                    d_d   = byte_sel(val_q, cnt_q, n_q);
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!en) begin
            st_q   <= CN_IDLE;
            here_q <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
            val_q  <= '0;
            bsy_q  <= 1'b0;
            dn_q   <= 1'b0;
            we_q   <= 1'b0;
            a_q    <= '0;
            d_q    <= '0;
        end else begin
            st_q   <= st_d;
            here_q <= here_d;
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            val_q  <= val_d;
            bsy_q  <= bsy_d;
            dn_q   <= dn_d;
            we_q   <= we_d;
            a_q    <= a_d;
            d_q    <= d_d;
        end
    end

    assign bsy    = bsy_q;
    assign dn     = dn_q;
    assign here   = here_q;
    assign mem_we = we_q;
    assign mem_a  = a_q;
    assign mem_d  = d_q;

endmodule
